ntt_writeback_sequencer: RTL

//  Write side of the NTT/INTT/PWM datapath. Captures the four coefficient-RAM read addresses issued each cycle by the

---
 rtl/ntt_writeback_sequencer_pkg.sv | 22 ++
 rtl/ntt_writeback_sequencer_if.sv | 48 ++++
 rtl/ntt_writeback_sequencer_wb_addr_pipe.sv | 42 ++++
 rtl/ntt_writeback_sequencer.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/ntt_writeback_sequencer_pkg.sv
// Shared constants, op encodings and FSM state type for the NTT write-back sequencer.
package ntt_writeback_sequencer_pkg;

    localparam int ADDR_W    = 7;
    localparam int DATA_W    = 24;
    localparam int DEF_LAT_A = 7;
    localparam int DEF_LAT_B = 10;

    localparam logic [2:0] OP_IDLE = 3'b000;
    localparam logic [2:0] OP_NTT  = 3'b001;
    localparam logic [2:0] OP_PWM  = 3'b010;
    localparam logic [2:0] OP_PWA  = 3'b110;
    localparam logic [2:0] OP_INTT = 3'b100;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } wb_state_e;

endpackage

// File: rtl/ntt_writeback_sequencer_if.sv
// Bus bundle between the address generator / butterfly side and the write-back sequencer.
interface ntt_writeback_sequencer_if;
    import ntt_writeback_sequencer_pkg::*;

    logic [2:0]        sel;
    logic              issue_vld;
    logic [ADDR_W-1:0] rd_addr_0;
    logic [ADDR_W-1:0] rd_addr_1;
    logic [ADDR_W-1:0] rd_addr_2;
    logic [ADDR_W-1:0] rd_addr_3;
    logic [1:0]        wen;
    logic              gen_done;
    logic [DATA_W-1:0] bf_a0;
    logic [DATA_W-1:0] bf_a1;
    logic [DATA_W-1:0] bf_b0;
    logic [DATA_W-1:0] bf_b1;
    logic              wr_en_a;
    logic [ADDR_W-1:0] wr_addr_0;
    logic [ADDR_W-1:0] wr_addr_1;
    logic [DATA_W-1:0] wr_data_0;
    logic [DATA_W-1:0] wr_data_1;
    logic              wr_en_b;
    logic [ADDR_W-1:0] wr_addr_2;
    logic [ADDR_W-1:0] wr_addr_3;
    logic [DATA_W-1:0] wr_data_2;
    logic [DATA_W-1:0] wr_data_3;
    logic              busy;
    logic              done;
    logic [7:0]        wr_count;
    logic              err;

    modport master (
        output sel, issue_vld, rd_addr_0, rd_addr_1, rd_addr_2, rd_addr_3,
               wen, gen_done, bf_a0, bf_a1, bf_b0, bf_b1,
        input  wr_en_a, wr_addr_0, wr_addr_1, wr_data_0, wr_data_1,
               wr_en_b, wr_addr_2, wr_addr_3, wr_data_2, wr_data_3,
               busy, done, wr_count, err
    );

    modport slave (
        input  sel, issue_vld, rd_addr_0, rd_addr_1, rd_addr_2, rd_addr_3,
               wen, gen_done, bf_a0, bf_a1, bf_b0, bf_b1,
        output wr_en_a, wr_addr_0, wr_addr_1, wr_data_0, wr_data_1,
               wr_en_b, wr_addr_2, wr_addr_3, wr_data_2, wr_data_3,
               busy, done, wr_count, err
    );

endinterface

// File: rtl/ntt_writeback_sequencer_wb_addr_pipe.sv
// Valid-tagged fixed-depth shift register; the last stage is the entry due for commit this cycle.
module wb_addr_pipe #(
    parameter int DEPTH = 7,
    parameter int W     = 14
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         clr,
    input  logic         in_vld,
    input  logic [W-1:0] in_data,
    output logic         head_vld,
    output logic [W-1:0] head_data,
    output logic         any_vld
);

    logic [DEPTH-1:0] vld_r;
    logic [W-1:0]     data_r [DEPTH];

    // Valid tags shift every cycle; reset or op start invalidates the whole line.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            vld_r <= '0;
        end else if (clr) begin
            vld_r <= '0;
        end else begin
            vld_r <= {vld_r[DEPTH-2:0], in_vld};
        end
    end

    // Address payload follows its tag; contents only matter where the tag is set.
    always_ff @(posedge clk) begin
        data_r[0] <= in_data;
        for (int i = 1; i < DEPTH; i++) begin
            data_r[i] <= data_r[i-1];
        end
    end

    assign head_vld  = vld_r[DEPTH-1];
    assign head_data = data_r[DEPTH-1];
    assign any_vld   = |vld_r;

endmodule

// File: rtl/ntt_writeback_sequencer.sv
// In-place write-back for the NTT/INTT/PWM datapath: delays read addresses to butterfly latency,
// commits results on the generator's wen strobes, flags strobe/address pairing errors.
module ntt_writeback_sequencer
    import ntt_writeback_sequencer_pkg::*;
#(
    parameter int LAT_A = DEF_LAT_A,
    parameter int LAT_B = DEF_LAT_B
) (
    input  logic                         clk,
    input  logic                         rstn,
    ntt_writeback_sequencer_if.slave     bus
);

    wb_state_e           state_r, state_n;
    logic                start_s, active_s;
    logic                head_a_vld_s, head_b_vld_s, any_a_s, any_b_s;
    logic [2*ADDR_W-1:0] head_a_s, head_b_s;
    logic                commit_a_s, commit_b_s, err_a_s, err_b_s;

    logic                wr_en_a_r, wr_en_b_r, busy_r, done_r, err_r;
    logic [ADDR_W-1:0]   wr_addr_0_r, wr_addr_1_r, wr_addr_2_r, wr_addr_3_r;
    logic [DATA_W-1:0]   wr_data_0_r, wr_data_1_r, wr_data_2_r, wr_data_3_r;
    logic [7:0]          wr_count_r;

    assign start_s  = (state_r == ST_IDLE) && (bus.sel != OP_IDLE);
    assign active_s = (state_r == ST_RUN) || (state_r == ST_DRAIN);

    wb_addr_pipe #(.DEPTH(LAT_A), .W(2*ADDR_W)) u_pipe_a (
        .clk       (clk),
        .rstn      (rstn),
        .clr       (start_s),
        .in_vld    (bus.issue_vld),
        .in_data   ({bus.rd_addr_1, bus.rd_addr_0}),
        .head_vld  (head_a_vld_s),
        .head_data (head_a_s),
        .any_vld   (any_a_s)
    );

    wb_addr_pipe #(.DEPTH(LAT_B), .W(2*ADDR_W)) u_pipe_b (
        .clk       (clk),
        .rstn      (rstn),
        .clr       (start_s),
        .in_vld    (bus.issue_vld),
        .in_data   ({bus.rd_addr_3, bus.rd_addr_2}),
        .head_vld  (head_b_vld_s),
        .head_data (head_b_s),
        .any_vld   (any_b_s)
    );

    // A strobe without a due address, or a due address without its strobe, is dropped and flagged.
    assign commit_a_s = active_s && bus.wen[1] && head_a_vld_s;
    assign commit_b_s = active_s && bus.wen[0] && head_b_vld_s;
    assign err_a_s    = active_s && (bus.wen[1] != head_a_vld_s);
    assign err_b_s    = active_s && (bus.wen[0] != head_b_vld_s);

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_n;
        end
    end

    // Next-state logic; sel is only looked at in IDLE, gen_done only in RUN.
    always_comb begin
        state_n = state_r;
        case (state_r)
            ST_IDLE: begin
                if (bus.sel != OP_IDLE) state_n = ST_RUN;
                else                    state_n = ST_IDLE;
            end
            ST_RUN: begin
                if (bus.gen_done) state_n = ST_DRAIN;
                else              state_n = ST_RUN;
            end
            ST_DRAIN: begin
                if (!any_a_s && !any_b_s) state_n = ST_DONE;
                else                      state_n = ST_DRAIN;
            end
            ST_DONE:  state_n = ST_IDLE;
            default:  state_n = ST_IDLE;
        endcase
    end

    // Registered write ports, status flags and commit counter.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_en_a_r   <= 1'b0;
            wr_en_b_r   <= 1'b0;
            wr_addr_0_r <= '0;
            wr_addr_1_r <= '0;
            wr_addr_2_r <= '0;
            wr_addr_3_r <= '0;
            wr_data_0_r <= '0;
            wr_data_1_r <= '0;
            wr_data_2_r <= '0;
            wr_data_3_r <= '0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            wr_count_r  <= 8'd0;
            err_r       <= 1'b0;
        end else begin
            wr_en_a_r <= commit_a_s;
            wr_en_b_r <= commit_b_s;
            busy_r    <= (state_n != ST_IDLE);
            done_r    <= (state_n == ST_DONE);
            if (commit_a_s) begin
                wr_addr_0_r <= head_a_s[ADDR_W-1:0];
                wr_addr_1_r <= head_a_s[2*ADDR_W-1:ADDR_W];
                wr_data_0_r <= bus.bf_a0;
                wr_data_1_r <= bus.bf_a1;
            end
            if (commit_b_s) begin
                wr_addr_2_r <= head_b_s[ADDR_W-1:0];
                wr_addr_3_r <= head_b_s[2*ADDR_W-1:ADDR_W];
                wr_data_2_r <= bus.bf_b0;
                wr_data_3_r <= bus.bf_b1;
            end
            if (start_s) begin
                wr_count_r <= 8'd0;
                err_r      <= 1'b0;
            end else begin
                if (commit_a_s && (wr_count_r != 8'hFF)) wr_count_r <= wr_count_r + 8'd1;
                if (err_a_s || err_b_s)                  err_r      <= 1'b1;
            end
        end
    end

    assign bus.wr_en_a   = wr_en_a_r;
    assign bus.wr_addr_0 = wr_addr_0_r;
    assign bus.wr_addr_1 = wr_addr_1_r;
    assign bus.wr_data_0 = wr_data_0_r;
    assign bus.wr_data_1 = wr_data_1_r;
    assign bus.wr_en_b   = wr_en_b_r;
    assign bus.wr_addr_2 = wr_addr_2_r;
    assign bus.wr_addr_3 = wr_addr_3_r;
    assign bus.wr_data_2 = wr_data_2_r;
    assign bus.wr_data_3 = wr_data_3_r;
    assign bus.busy      = busy_r;
    assign bus.done      = done_r;
    assign bus.wr_count  = wr_count_r;
    assign bus.err       = err_r;

endmodule
